// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute unit and ALU control.
// Holds the operation codes driven on opt and the execute-unit state encoding.
package alu_exec_pkg;

  // Operation codes on opt
  localparam logic [3:0] OptAnd   = 4'b0000;
  localparam logic [3:0] OptOrr   = 4'b0001;
  localparam logic [3:0] OptAdd   = 4'b0010;
  localparam logic [3:0] OptSub   = 4'b0110;
  localparam logic [3:0] OptPassB = 4'b0111;
  localparam logic [3:0] OptMul   = 4'b1000;

  // StIdle: no result held; StBusy: multiplier iterating; StHold: result held.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StHold = 2'b10
  } state_e;

  function automatic logic opt_is_legal(logic [3:0] op);
    return (op == OptAnd) || (op == OptOrr) || (op == OptAdd) ||
           (op == OptSub) || (op == OptPassB) || (op == OptMul);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, low Width bits of a*b.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start_i     load operands; steps begin on the following cycle
//   a_i, b_i    operands, sampled when start_i is high
//   done_o      high during the cycle whose step is the final (Width-th) one
//   product_o   product value valid while done_o is high
module alu_mul_seq #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] product_o
);

  localparam int unsigned CntW = $clog2(Width) + 1;

  logic             active_q, active_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] mcand_q, mcand_d;
  logic [Width-1:0] mplier_q, mplier_d;
  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] acc_next;
  logic             last_step;

  always_comb begin
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_step = active_q && (cnt_q == CntW'(Width - 1));
    done_o    = last_step;
    // Final accumulation is exposed combinationally so the parent can
    // register it on the same edge as the last step.
    product_o = acc_next;

    active_d = active_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;

    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end else if (active_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_step) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: AND, ORR, ADD, SUB, PASS_B in one cycle, MUL via an
// iterative multiplier, with a valid/ready request side and a held result.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   in_valid, in_ready    request handshake; opt/a/b sampled on transfer
//   opt, a, b             operation code and operands
//   out_valid, out_ready  result handshake; result and flags held until taken
//   result, zero, neg, carry, ovf, illegal  registered result and flags
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             is_mul;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_ill;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic             load;
  logic [WIDTH-1:0] load_res;
  logic             load_carry;
  logic             load_ovf;
  logic             load_ill;

  alu_mul_seq #(
    .Width (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Single-cycle datapath
  always_comb begin
    is_sub    = (opt == OptSub);
    is_mul    = (opt == OptMul);
    b_eff     = is_sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    if (!opt_is_legal(opt)) begin
      alu_ill = 1'b1;
    end else if (opt == OptAnd) begin
      alu_res = a & b;
    end else if (opt == OptOrr) begin
      alu_res = a | b;
    end else if ((opt == OptAdd) || is_sub) begin
      alu_res   = sum[WIDTH-1:0];
      alu_carry = sum[WIDTH];
      alu_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (opt == OptPassB) begin
      alu_res = b;
    end
  end

  // Control and result register next-state
  always_comb begin
    in_ready    = (state_q == StIdle) || ((state_q == StHold) && out_ready);
    accept      = in_valid && in_ready;
    mul_start   = accept && is_mul;

    state_d     = state_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    load_res    = alu_res;
    load_carry  = alu_carry;
    load_ovf    = alu_ovf;
    load_ill    = alu_ill;

    unique case (state_q)
      StIdle, StHold: begin
        if (accept) begin
          if (is_mul) begin
            state_d     = StBusy;
            out_valid_d = 1'b0;
          end else begin
            state_d     = StHold;
            out_valid_d = 1'b1;
            load        = 1'b1;
          end
        end else if ((state_q == StHold) && out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      StBusy: begin
        if (mul_done) begin
          state_d     = StHold;
          out_valid_d = 1'b1;
          load        = 1'b1;
          load_res    = mul_product;
          load_carry  = 1'b0;
          load_ovf    = 1'b0;
          load_ill    = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    endcase

    result_d  = load ? load_res : result_q;
    zero_d    = load ? (load_res == '0) : zero_q;
    neg_d     = load ? load_res[WIDTH-1] : neg_q;
    carry_d   = load ? load_carry : carry_q;
    ovf_d     = load ? load_ovf : ovf_q;
    illegal_d = load ? load_ill : illegal_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=64). Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opt;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, neg, carry, ovf, illegal;

  int vectors = 0;
  int errors  = 0;

  // {out_valid, result, zero, neg, carry, ovf, illegal}
  logic [W+5:0] got, exp;

  alu_exec_unit #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opt       (opt),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [W+5:0] obs();
    return {out_valid, result, zero, neg, carry, ovf, illegal};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opt = OptAnd; a = '0; b = '0;
    #12;
    got = obs(); exp = '0;
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_state: got %h want %h", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    out_ready = 1'b1; in_valid = 1'b1; opt = OptAdd;
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1;
    @(negedge clk);
    in_valid = 1'b0;
    got = obs(); exp = {1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL add_ovf: got %h want %h", got, exp);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL add_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_sub();
    out_ready = 1'b1; in_valid = 1'b1; opt = OptSub; a = 64'd5; b = 64'd5;
    @(negedge clk);
    got = obs(); exp = {1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL sub_equal: got %h want %h", got, exp);
    end
    a = 64'd0; b = 64'd1;
    @(negedge clk);
    in_valid = 1'b0;
    got = obs(); exp = {1'b1, {W{1'b1}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL sub_borrow: got %h want %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    int n;
    int busy_bad;
    out_ready = 1'b1; in_valid = 1'b1; opt = OptMul; a = 64'd3; b = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0; busy_bad = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (in_ready !== 1'b0) busy_bad++;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 64 || busy_bad != 0) begin
      errors++;
      $display("FAIL mul_latency: busy cycles got %0d want 64, ready-while-busy %0d want 0",
               n, busy_bad);
    end
    got = obs(); exp = {1'b1, 64'd21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL mul_3x7: got %h want %h", got, exp);
    end
    @(negedge clk);
    in_valid = 1'b1; a = 64'h1_0000_0000; b = 64'h1_0000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    got = obs(); exp = {1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp || n != 64) begin
      errors++; $display("FAIL mul_wrap: got %h want %h (busy %0d want 64)", got, exp, n);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    a = 64'hF0F0_F0F0_F0F0_F0F0; b = 64'hFF00_FF00_FF00_FF00;
    opt = OptAnd;
    @(negedge clk);
    got = obs(); exp = {1'b1, 64'hF000_F000_F000_F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL b2b_and: got %h want %h", got, exp);
    end
    opt = OptOrr;
    @(negedge clk);
    got = obs(); exp = {1'b1, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL b2b_orr: got %h want %h", got, exp);
    end
    opt = OptPassB;
    @(negedge clk);
    got = obs(); exp = {1'b1, 64'hFF00_FF00_FF00_FF00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL b2b_passb: got %h want %h", got, exp);
    end
    // Stall: a pending AND must wait behind the held PASS_B result.
    out_ready = 1'b0; opt = OptAnd; a = 64'd1; b = 64'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = obs();
      vectors++;
      if (got !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: got %h ready %b want %h ready 0", i, got, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = obs(); exp = {1'b1, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL after_stall: got %h want %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; opt = 4'b1111; a = 64'd5; b = 64'd3;
    @(negedge clk);
    got = obs(); exp = {1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL illegal_op: got %h want %h", got, exp);
    end
    opt = OptAdd; a = 64'd1; b = 64'd2;
    @(negedge clk);
    in_valid = 1'b0;
    got = obs(); exp = {1'b1, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL illegal_clear: got %h want %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    out_ready = 1'b1; in_valid = 1'b1; opt = OptMul; a = 64'd3; b = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    got = obs(); exp = '0;
    vectors++;
    if (got !== exp || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_mul: got %h ready %b want %h ready 1", got, in_ready, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++; $display("FAIL no_result_after_reset: out_valid cycles got %0d want 0", seen);
    end
    in_valid = 1'b1; opt = OptAdd; a = 64'd2; b = 64'd3;
    @(negedge clk);
    in_valid = 1'b0;
    got = obs(); exp = {1'b1, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors++;
    if (got !== exp) begin
      errors++; $display("FAIL post_reset_add: got %h want %h", got, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
